// File: rtl/uc_secuencial.sv
// uc_secuencial: multi-cycle control unit for the 10-bit-PC microcontroller.
// Each instruction takes two cycles: FETCH lets the instruction and zero flag
// settle, and EXEC drives the decoded datapath strobes. The datapath commits
// its writes on the clock edge that ends EXEC. A run/step/halt handshake lets
// a host start, single-step and stop the core. A counter tracks the number of
// retired instructions.
module uc_secuencial #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t state;
  logic   one_shot;

  // Opcode class decode.
  logic op_alu;
  logic op_li;
  logic op_j;
  logic op_jz;
  logic op_jnz;
  logic op_halt;
  logic op_rsv;

  // Classify the opcode. NOP (010011) needs no flag: it takes the defaults.
  always_comb begin
    op_alu  = Opcode[5];
    op_li   = (Opcode[5:4] == 2'b00);
    op_j    = (Opcode == 6'b010000);
    op_jz   = (Opcode == 6'b010001);
    op_jnz  = (Opcode == 6'b010010);
    op_halt = (Opcode[5:2] == 4'b0101);
    op_rsv  = (Opcode[5:3] == 3'b011);
  end

  // Strobes come straight from the state. This way, an asynchronous reset
  // during EXEC drops every write enable at once, and no datapath write occurs
  // on the following edge.
  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    Op     = '0;
    pc_we  = 1'b0;
    halted = (state == S_HALT);
    if (state == S_EXEC) begin
      // A HALT opcode does not write the PC, so the PC stays on it.
      pc_we = ~op_halt;
      if (op_alu) begin
        Op  = Opcode[4:2];
        we3 = 1'b1;
        wez = 1'b1;
      end else if (op_li) begin
        we3   = 1'b1;
        s_inm = 1'b1;
      end else if (op_j) begin
        s_inc = 1'b0;
      end else if (op_jz) begin
        s_inc = ~z;
      end else if (op_jnz) begin
        s_inc = z;
      end
    end
  end

  // Sequencer: HALT -> FETCH -> EXEC -> (FETCH | HALT). This block also holds
  // the step latch, the sticky illegal flag and the retired-instruction
  // counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_HALT;
      one_shot <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      case (state)
        S_HALT: begin
          if (run || step) begin
            state    <= S_FETCH;
            one_shot <= step;
          end
        end
        S_FETCH: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          one_shot <= 1'b0;
          if (!op_halt) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (op_rsv) begin
            illegal <= 1'b1;
          end
          if (op_halt || one_shot || !run) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule
